sa_run_sequencer: RTL
=====================

Name: sa_run_sequencer

Overview:
Run controller that sequences one complete matrix operation on the systolic-array top level. It accepts a byte stream through a valid/ready handshake and steers the first WEIGHT_BYTES to the weight (north) input FIFOs and the next DATA_BYTES to the data (west) input FIFOs. It then fires the array triggers, waits a fixed compute window and holds a drain window open for the output FIFOs. It sits between the host or DMA stream and the top-level data_in, i_sel_1, i_sel_2, i_trigger_1 and i_trigger_2 pins.

Parameters:
ROW, 9, systolic array rows
COL, 32, systolic array columns
W_DATA, 8, stream byte width
WEIGHT_BYTES, ROW*COL (288), bytes routed to the weight FIFOs per run
DATA_BYTES, ROW*COL (288), bytes routed to the data FIFOs per run
COMPUTE_CYCLES, ROW+COL+7 (48), cycles from trigger to start of drain; must be ≥1
DRAIN_CYCLES, COL (32), cycles o_drain is held high; must be ≥1
CNT_W, 10, phase counter width; must be ≥ $clog2 of the largest of the four counts

Ports:
i_clk  in  1  clock; all state changes on the rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_start  in  1  begin a run; sampled only in IDLE
i_abort  in  1  synchronous abort; forces IDLE from any state
s_valid  in  1  stream byte valid
s_data  in  W_DATA  stream byte
s_ready  out  1  stream ready
o_data  out  W_DATA  registered byte to top-level data_in
o_data_vld  out  1  o_data carries an accepted byte this cycle
o_sel_1  out  1  weight-path select; aligned with o_data_vld
o_sel_2  out  1  data-path select; aligned with o_data_vld
o_trigger_1  out  1  weight-FIFO read trigger pulse
o_trigger_2  out  1  data-FIFO read trigger pulse
o_drain  out  1  output-FIFO drain window
o_busy  out  1  state is not IDLE
o_done  out  1  one-cycle run-complete pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE, counter=0. All outputs are 0, including o_data.
- Only a Moore FSM with one CNT_W counter. The counter clears on every state entry.
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.
- IDLE: s_ready=0, o_busy=0. If i_start=1, go to LOAD_W.
- LOAD_W: s_ready=1.
  - Each handshake (s_valid&s_ready) increments the counter.
  - The handshake on count WEIGHT_BYTES-1 moves to LOAD_D.
  - No handshake means hold with the counter unchanged.
- LOAD_D: s_ready=1. Counting is the same as LOAD_W. The handshake on count DATA_BYTES-1 moves to FIRE.
- Byte forwarding:
  - The cycle after a handshake: o_data=s_data, o_data_vld=1.
  - o_sel_1=1 if the byte was accepted in LOAD_W; o_sel_2=1 if accepted in LOAD_D.
  - Otherwise o_data_vld, o_sel_1 and o_sel_2 are 0, and o_data holds its last value.
  - o_sel_1 and o_sel_2 are never both 1.
- FIRE: one cycle with o_trigger_1=o_trigger_2=1, s_ready=0. Then go to COMPUTE.
- COMPUTE: counts every cycle. At count COMPUTE_CYCLES-1, go to DRAIN.
- DRAIN: o_drain=1. Counts every cycle. At count DRAIN_CYCLES-1, go to DONE.
- DONE: o_done=1 for one cycle. Then go to IDLE.
- o_busy=1 in every state except IDLE.
- Latency: with s_valid held high, o_done asserts exactly WEIGHT_BYTES+DATA_BYTES+COMPUTE_CYCLES+DRAIN_CYCLES+2 cycles after the edge that samples i_start. With defaults this is 658.
- i_start outside IDLE is ignored and does not queue. i_start in DONE is ignored; a new run needs i_start in IDLE.
- i_abort (priority over everything):
  - The next state is IDLE and the counter becomes 0.
  - o_data_vld, o_sel_1, o_sel_2, the triggers, o_drain and o_done are 0 the next cycle.
  - Any handshake in the abort cycle is still forwarded, since it was accepted, but it is not counted. o_done is never produced for an aborted run.
- i_abort and i_start together in IDLE: stay in IDLE.
- s_valid in IDLE, FIRE, COMPUTE, DRAIN or DONE: no handshake (s_ready=0) and the byte is not consumed.
- Reset mid-run: immediate return to the reset values. No partial trigger or done pulse.

Test Plan:
- Reset then idle: hold i_rst_n=0 for 3 cycles with s_valid=1, then release. All outputs stay 0 and s_ready=0 until i_start.
- Full run, defaults, s_valid constant 1, s_data=count[7:0]:
  - 288 beats with o_sel_1=1, then 288 beats with o_sel_2=1.
  - Triggers pulse together for 1 cycle, o_drain is high for 32 cycles, and o_done appears 658 cycles after start.
- Backpressure: s_valid toggles 1,0,1,0. The handshake count still equals 288+288. o_done is delayed by exactly the number of invalid LOAD cycles.
- Boundary: the last weight byte is immediately followed by the first data byte. The o_sel_1→o_sel_2 switch happens on consecutive o_data_vld cycles with no gap and no overlap.
- Abort:
  - i_abort at LOAD_D count 100 gives o_busy=0 the next cycle, with no trigger and no o_done.
  - A fresh i_start then requires 288 weight bytes again.
- i_start pulsed during COMPUTE and DONE: ignored. Exactly one o_done per accepted start.

Source files
------------

// File: rtl/sa_run_sequencer.sv
// sa_run_sequencer: sequences one systolic-array run.
//   Stream bytes in over s_valid/s_ready. The first WEIGHT_BYTES go to the
//   weight (north) FIFOs and the next DATA_BYTES go to the data (west) FIFOs.
//   Then the FSM fires both read triggers, waits COMPUTE_CYCLES, holds a
//   DRAIN_CYCLES drain window, and pulses o_done.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_start, i_abort        run start (IDLE only), synchronous abort
//   s_valid/s_data/s_ready  byte stream input
//   o_data/o_data_vld       registered forwarded byte
//   o_sel_1/o_sel_2         weight/data path select, aligned with o_data_vld
//   o_trigger_1/2           FIFO read trigger pulses
//   o_drain                 output-FIFO drain window
//   o_busy/o_done           not-IDLE flag, run-complete pulse
module sa_run_sequencer #(
    parameter int unsigned ROW            = 9,
    parameter int unsigned COL            = 32,
    parameter int unsigned W_DATA         = 8,
    parameter int unsigned WEIGHT_BYTES   = ROW * COL,
    parameter int unsigned DATA_BYTES     = ROW * COL,
    parameter int unsigned COMPUTE_CYCLES = ROW + COL + 7,
    parameter int unsigned DRAIN_CYCLES   = COL,
    parameter int unsigned CNT_W          = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              s_valid,
    input  logic [W_DATA-1:0] s_data,
    output logic              s_ready,
    output logic [W_DATA-1:0] o_data,
    output logic              o_data_vld,
    output logic              o_sel_1,
    output logic              o_sel_2,
    output logic              o_trigger_1,
    output logic              o_trigger_2,
    output logic              o_drain,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WEIGHT_BYTES - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_BYTES - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_D  = 3'd2,
        FIRE    = 3'd3,
        COMPUTE = 3'd4,
        DRAIN   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W_DATA-1:0]   data_q, data_d;
    logic                vld_q, vld_d;
    logic                sel1_q, sel1_d;
    logic                sel2_q, sel2_d;
    logic                trig_q, trig_d;
    logic                drain_q, drain_d;
    logic                done_q, done_d;
    logic                ready;
    logic                hs;

    // Stream acceptance is a pure decode of the state register.
    assign ready = (state_q == LOAD_W) || (state_q == LOAD_D);
    assign hs    = s_valid && ready;

    // State register and output flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sel1_q  <= 1'b0;
            sel2_q  <= 1'b0;
            trig_q  <= 1'b0;
            drain_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            trig_q  <= trig_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        sel1_d  = 1'b0;
        sel2_d  = 1'b0;
        trig_d  = 1'b0;
        drain_d = 1'b0;
        done_d  = 1'b0;

        // An accepted byte is always forwarded, even in an abort cycle.
        if (hs) begin
            data_d = s_data;
            vld_d  = 1'b1;
            sel1_d = (state_q == LOAD_W);
            sel2_d = (state_q == LOAD_D);
        end

        // Control pulses lag the state by one cycle so the trigger follows
        // the last forwarded data byte into the FIFOs.
        trig_d  = (state_q == FIRE);
        drain_d = (state_q == DRAIN);
        done_d  = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                end
            end
            LOAD_W: begin
                if (hs) begin
                    if (cnt_q == W_LAST) begin
                        state_d = LOAD_D;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_D: begin
                if (hs) begin
                    if (cnt_q == D_LAST) begin
                        state_d = FIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIRE: begin
                state_d = COMPUTE;
                cnt_d   = '0;
            end
            COMPUTE: begin
                if (cnt_q == C_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == R_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides everything except forwarding of an accepted byte.
        if (i_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            trig_d  = 1'b0;
            drain_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign s_ready     = ready;
    assign o_busy      = (state_q != IDLE);
    assign o_data      = data_q;
    assign o_data_vld  = vld_q;
    assign o_sel_1     = sel1_q;
    assign o_sel_2     = sel2_q;
    assign o_trigger_1 = trig_q;
    assign o_trigger_2 = trig_q;
    assign o_drain     = drain_q;
    assign o_done      = done_q;

endmodule
